// File: rtl/fast_field_framer_pkg.sv
// fast_pkg: shared types and constants for the FAST field framer
// Contents: default field length, byte type, stop-bit position, framer state enum.
package fast_pkg;
   localparam int MAX_BYTES_DEF = 10;
   localparam int STOP_BIT = 7;
   typedef logic [7:0] fast_byte_t;
   typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} framer_state_t;
endpackage

// File: rtl/fast_field_framer.sv
// fast_field_framer: splits a FAST byte stream into stop-bit delimited fields
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last - input byte stream (s_data[7] is the stop bit)
//   m_valid/m_ready          - field handshake towards the integer decoder
//   m_bytes, m_count, m_last - field bytes (index 0 first), byte count, message-end flag
//   err_overlong, err_trunc  - one-cycle error pulses
//   field_cnt, err_cnt       - saturating statistics, only with FAST_FRAMER_STATS_EN defined
module fast_field_framer
   import fast_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF,
   parameter int CNT_W = $clog2(MAX_BYTES) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [7:0]                  s_data,
   input  logic                        s_last,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [MAX_BYTES-1:0][7:0]   m_bytes,
   output logic [CNT_W-1:0]            m_count,
   output logic                        m_last,
   output logic                        err_overlong,
   output logic                        err_trunc
`ifdef FAST_FRAMER_STATS_EN
   ,
   output logic [31:0]                 field_cnt,
   output logic [15:0]                 err_cnt
`endif
);
   framer_state_t                state;
   logic [CNT_W-1:0]             wr_idx;
   fast_byte_t [MAX_BYTES-1:0]   buf_q;
   fast_byte_t [MAX_BYTES-1:0]   merged;
   logic                         acc;
   logic                         stop;
   // In HOLD the input only advances when the held field is taken, so
   // s_ready depends on m_ready and state only, never on s_data.
   assign s_ready = !rst && ((state == HOLD) ? m_ready : 1'b1);
   assign acc = s_valid && s_ready;
   assign stop = s_data[STOP_BIT];
   always_comb begin
      merged = buf_q;
      for (int i = 0; i < MAX_BYTES; i++)
         merged[i] = (wr_idx == CNT_W'(i)) ? s_data : buf_q[i];
   end
   always_ff @(posedge clk) begin
      err_overlong <= 1'b0;
      err_trunc <= 1'b0;
      if (rst) begin
         state <= COLLECT;
         wr_idx <= '0;
         buf_q <= '0;
         m_valid <= 1'b0;
         m_bytes <= '0;
         m_count <= '0;
         m_last <= 1'b0;
      end else if (state == COLLECT) begin
         if (acc) begin
            if (stop) begin
               m_bytes <= merged;
               m_count <= wr_idx + CNT_W'(1);
               m_last <= s_last;
               m_valid <= 1'b1;
               wr_idx <= '0;
               buf_q <= '0;
               state <= HOLD;
            end else if (wr_idx == CNT_W'(MAX_BYTES - 1)) begin
               // An overlong byte that also ends the message leaves nothing to drain.
               err_overlong <= 1'b1;
               wr_idx <= '0;
               buf_q <= '0;
               state <= s_last ? COLLECT : DRAIN;
            end else if (s_last) begin
               err_trunc <= 1'b1;
               wr_idx <= '0;
               buf_q <= '0;
            end else begin
               buf_q <= merged;
               wr_idx <= wr_idx + CNT_W'(1);
            end
         end
      end else if (state == HOLD) begin
         if (m_ready) begin
            if (acc && stop) begin
               m_bytes <= '0;
               m_bytes[0] <= s_data;
               m_count <= CNT_W'(1);
               m_last <= s_last;
            end else begin
               m_valid <= 1'b0;
               state <= COLLECT;
               if (acc && s_last) begin
                  err_trunc <= 1'b1;
               end else if (acc) begin
                  buf_q[0] <= s_data;
                  wr_idx <= CNT_W'(1);
               end
            end
         end
      end else begin
         if (acc && (stop || s_last))
            state <= COLLECT;
      end
   end
`ifdef FAST_FRAMER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         field_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (m_valid && m_ready && field_cnt != '1)
            field_cnt <= field_cnt + 32'd1;
         if ((err_overlong || err_trunc) && err_cnt != '1)
            err_cnt <= err_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fast_field_framer.sv
// tb_fast_field_framer: directed self-checking bench for fast_field_framer
module tb_fast_field_framer;
   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [7:0]       s_data;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [9:0][7:0]  m_bytes;
   logic [4:0]       m_count;
   logic             m_last;
   logic             err_overlong;
   logic             err_trunc;
`ifdef FAST_FRAMER_STATS_EN
   logic [31:0]      field_cnt;
   logic [15:0]      err_cnt;
`endif
   int checks = 0;
   int errors = 0;
   logic [9:0][7:0] exp_bytes;

   fast_field_framer dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_bytes(m_bytes), .m_count(m_count),
      .m_last(m_last), .err_overlong(err_overlong), .err_trunc(err_trunc)
`ifdef FAST_FRAMER_STATS_EN
      , .field_cnt(field_cnt), .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l);
      s_valid = v;
      s_data = d;
      s_last = l;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_ready = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      tick();
      tick();
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
      checks++;
      if ({m_valid, m_last, err_overlong, err_trunc} !== 4'b0000 || m_count !== 5'd0 || m_bytes !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b ovl=%b trunc=%b count=%0d bytes=%h want all 0",
                  m_valid, m_last, err_overlong, err_trunc, m_count, m_bytes);
      end
      rst = 1'b0;
      #1;
   endtask

   task automatic test_two_byte();
      m_ready = 1'b1;
      drive(1'b1, 8'h01, 1'b0);
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL two_byte_early_valid: got %b want 0", m_valid); end
      drive(1'b1, 8'h82, 1'b0);
      tick();
      exp_bytes = '0;
      exp_bytes[0] = 8'h01;
      exp_bytes[1] = 8'h82;
      checks++;
      if (m_valid !== 1'b1 || m_count !== 5'd2 || m_last !== 1'b0) begin
         errors++;
         $display("FAIL two_byte_field: got valid=%b count=%0d last=%b want 1 2 0", m_valid, m_count, m_last);
      end
      checks++;
      if (m_bytes !== exp_bytes) begin errors++; $display("FAIL two_byte_bytes: got %h want %h", m_bytes, exp_bytes); end
      drive(1'b0, 8'h00, 1'b0);
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL two_byte_consumed: got %b want 0", m_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [3];
      seq = '{8'h81, 8'h80, 8'h83};
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, seq[i], 1'b0);
         #1;
         checks++;
         if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready[%0d]: got %b want 1", i, s_ready); end
         tick();
         checks++;
         if (m_valid !== 1'b1 || m_count !== 5'd1 || m_bytes[0] !== seq[i] || m_bytes[1] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_field[%0d]: got valid=%b count=%0d b0=%h b1=%h want 1 1 %h 00",
                     i, m_valid, m_count, m_bytes[0], m_bytes[1], seq[i]);
         end
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", m_valid); end
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      drive(1'b1, 8'h85, 1'b0);
      tick();
      drive(1'b1, 8'h07, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_count !== 5'd1 || m_bytes[0] !== 8'h85) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got s_ready=%b valid=%b count=%0d b0=%h want 0 1 1 85",
                     i, s_ready, m_valid, m_count, m_bytes[0]);
         end
         tick();
      end
      m_ready = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", s_ready); end
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", m_valid); end
      drive(1'b1, 8'h88, 1'b0);
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_count !== 5'd2 || m_bytes[0] !== 8'h07 || m_bytes[1] !== 8'h88) begin
         errors++;
         $display("FAIL bp_next_field: got valid=%b count=%0d b0=%h b1=%h want 1 2 07 88",
                  m_valid, m_count, m_bytes[0], m_bytes[1]);
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
   endtask

   task automatic test_max_len();
      m_ready = 1'b1;
      exp_bytes = '0;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 8'h10 + 8'(i), 1'b0);
         exp_bytes[i] = 8'h10 + 8'(i);
         tick();
      end
      drive(1'b1, 8'h99, 1'b0);
      exp_bytes[9] = 8'h99;
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_count !== 5'd10 || err_overlong !== 1'b0 || m_bytes !== exp_bytes) begin
         errors++;
         $display("FAIL max_len: got valid=%b count=%0d ovl=%b bytes=%h want 1 10 0 %h",
                  m_valid, m_count, err_overlong, m_bytes, exp_bytes);
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
   endtask

   task automatic test_overlong();
      int ovl = 0;
      int vld = 0;
      int trc = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, (i == 11) ? 8'h81 : 8'h7F, 1'b0);
         tick();
         ovl += int'(err_overlong);
         vld += int'(m_valid);
         trc += int'(err_trunc);
         if (i == 9) begin
            checks++;
            if (err_overlong !== 1'b1) begin errors++; $display("FAIL overlong_pulse_byte10: got %b want 1", err_overlong); end
         end
      end
      checks++;
      if (ovl != 1 || vld != 0 || trc != 0) begin
         errors++;
         $display("FAIL overlong_totals: got ovl=%0d valid=%0d trunc=%0d want 1 0 0", ovl, vld, trc);
      end
      drive(1'b1, 8'h90, 1'b0);
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_count !== 5'd1 || m_bytes[0] !== 8'h90) begin
         errors++;
         $display("FAIL overlong_recover: got valid=%b count=%0d b0=%h want 1 1 90", m_valid, m_count, m_bytes[0]);
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
   endtask

   task automatic test_trunc();
      m_ready = 1'b1;
      drive(1'b1, 8'h05, 1'b1);
      tick();
      checks++;
      if (err_trunc !== 1'b1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL trunc_pulse: got trunc=%b valid=%b want 1 0", err_trunc, m_valid);
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
      checks++;
      if (err_trunc !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL trunc_one_cycle: got trunc=%b valid=%b want 0 0", err_trunc, m_valid);
      end
      drive(1'b1, 8'h86, 1'b1);
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_last !== 1'b1 || m_count !== 5'd1 || m_bytes[0] !== 8'h86) begin
         errors++;
         $display("FAIL trunc_last_field: got valid=%b last=%b count=%0d b0=%h want 1 1 1 86",
                  m_valid, m_last, m_count, m_bytes[0]);
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b1;
      drive(1'b1, 8'h01, 1'b0);
      tick();
      drive(1'b1, 8'h02, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      tick();
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_count !== 5'd0 || m_bytes !== '0 || m_last !== 1'b0 ||
          err_overlong !== 1'b0 || err_trunc !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got s_ready=%b valid=%b count=%0d bytes=%h last=%b ovl=%b trunc=%b want all 0",
                  s_ready, m_valid, m_count, m_bytes, m_last, err_overlong, err_trunc);
      end
      rst = 1'b0;
      drive(1'b1, 8'h83, 1'b0);
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_count !== 5'd1 || m_bytes[0] !== 8'h83 || m_bytes[1] !== 8'h00 || err_trunc !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_next: got valid=%b count=%0d b0=%h b1=%h trunc=%b want 1 1 83 00 0",
                  m_valid, m_count, m_bytes[0], m_bytes[1], err_trunc);
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_two_byte();
      test_back_to_back();
      test_backpressure();
      test_max_len();
      test_overlong();
      test_trunc();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fast_field_framer.md
FAST_FIELD_FRAMER -- requirements
Module: fast_field_framer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 10, meaning the maximum bytes per FAST field.
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_BYTES)+1, meaning the width of the byte count.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_valid, input, 1, upstream byte valid.
REQ-006 SHALL have port s_ready, output, 1, byte accepted when s_valid && s_ready.
REQ-007 SHALL have port s_data, input, 8, stream byte, where bit7 is the FAST stop bit.
REQ-008 SHALL have port s_last, input, 1, marks the final byte of a FAST message.
REQ-009 SHALL have port m_valid, output, 1, field available to the uint/int decoder stage.
REQ-010 SHALL have port m_ready, input, 1, decoder consumes the field when m_valid && m_ready.
REQ-011 SHALL have port m_bytes, output, [MAX_BYTES-1:0][7:0], field bytes; index 0 holds the first (most significant) byte; unused slots are 0.
REQ-012 SHALL have port m_count, output, CNT_W, number of valid bytes (1..MAX_BYTES).
REQ-013 SHALL have port m_last, output, 1, the field ended on a byte that carried s_last.
REQ-014 SHALL have port err_overlong, output, 1, one-cycle pulse when a field exceeds MAX_BYTES.
REQ-015 SHALL have port err_trunc, output, 1, one-cycle pulse when s_last arrives mid-field.

Function
REQ-016 SHALL implement FSM states COLLECT, HOLD, DRAIN.
REQ-017 In COLLECT, s_ready SHALL be 1; each accepted byte SHALL be stored at index wr_idx, and wr_idx SHALL increment.
REQ-018 On acceptance of a byte with bit7=1 in COLLECT, the framer SHALL load m_bytes/m_count/m_last from the buffer plus that byte, set m_valid=1 next cycle (latency 1 cycle), clear wr_idx and the buffer, and go to HOLD.
REQ-019 In HOLD, s_ready SHALL equal m_ready, with no combinational path from s_data to s_ready.
REQ-020 In HOLD, m_ready=1 with no byte accepted SHALL clear m_valid and go to COLLECT.
REQ-021 In HOLD, m_ready=1 with a non-stop byte accepted SHALL clear m_valid, store the byte at index 0, and go to COLLECT.
REQ-022 In HOLD, m_ready=1 with a stop byte accepted SHALL reload the output with a 1-byte field, keep m_valid=1, and stay in HOLD, giving one field per cycle.
REQ-023 In HOLD, m_valid=1 and m_ready=0 SHALL hold m_bytes/m_count/m_last stable.
REQ-024 Accepting the MAX_BYTES-th byte with bit7=0 SHALL pulse err_overlong and go to DRAIN; no field SHALL be emitted.
REQ-025 In DRAIN, s_ready SHALL be 1 and bytes SHALL be discarded up to and including the next stop byte or s_last byte, then go to COLLECT; err_trunc SHALL NOT pulse in DRAIN.
REQ-026 In COLLECT, an accepted byte with s_last=1 and bit7=0 SHALL pulse err_trunc, discard the partial field, clear wr_idx, and stay in COLLECT.
REQ-027 A stop byte at index MAX_BYTES-1 SHALL be a legal field with m_count=MAX_BYTES.

Reset
REQ-028 While rst=1, the framer SHALL set state=COLLECT, wr_idx=0, buffer=0, m_valid=0, m_bytes=0, m_count=0, m_last=0, err_overlong=0, err_trunc=0.
REQ-029 While rst=1, s_ready SHALL be 0.
REQ-030 Reset mid-field or mid-HOLD SHALL drop the partial or held field with no error pulse.

Configuration
REQ-031 With FAST_FRAMER_STATS_EN defined, the framer SHALL add output field_cnt[31:0] (fields handed off) and output err_cnt[15:0] (overlong+trunc events), both saturating and cleared by rst.
REQ-032 Without FAST_FRAMER_STATS_EN, those ports and their counters SHALL be absent.

Structure
REQ-033 Package fast_pkg SHALL hold the MAX_BYTES default, the fast_byte_t typedef (logic [7:0]), STOP_BIT=7, and the framer state enum.
REQ-034 The framer SHALL be a single module with no sub-module.

Verification
REQ-035 The bench SHALL drive bytes 0x01,0x82 with m_ready=1 and check m_valid 1 cycle after 0x82, m_count=2, m_bytes[0]=0x01, m_bytes[1]=0x82, others 0.
REQ-036 The bench SHALL drive 0x81,0x80,0x83 back-to-back with m_ready=1 and check three consecutive m_valid cycles with m_count=1 each and s_ready held high.
REQ-037 The bench SHALL hold m_ready=0 for 5 cycles after field 0x85 and check s_ready=0 and outputs stable, then check that a byte accepted with m_ready=1 starts the next field.
REQ-038 The bench SHALL drive 11 bytes 0x7F then 0x81 and check one err_overlong pulse on byte 10, no field emitted, and that the following 0x90 yields m_count=1.
REQ-039 The bench SHALL drive 0x05 with s_last=1 and check an err_trunc pulse and no m_valid; then drive 0x86 with s_last=1 and check m_last=1.
REQ-040 The bench SHALL assert rst for 1 cycle after bytes 0x01,0x02 and check all outputs at reset values; then drive 0x83 and check m_count=1.
